// File: rtl/keypad_pkg.sv
// Shared types, the 4x4 legend and a popcount helper for the keypad scanner.
package keypad_pkg;

  // Event FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  // Hex legend of the standard 4x4 Pmod keypad, indexed by row*4+col.
  // Column 0 rows 0..3 = 1,4,7,0; column 1 = 2,5,8,F; column 2 = 3,6,9,E;
  // column 3 = A,B,C,D.
  localparam logic [3:0] KEY_LEGEND [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Number of set bits; callers zero-extend their key maps to 64 bits.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_event_fsm.sv
// Turns the debounced key map into press/release events for one key.
// Evaluated only when frame_stb is high (one cycle after the map updates).
// Handshake note: press_valid and release_valid are one-cycle pulses with
// no ready/back-pressure; the consumer must sample them every cycle, and
// key is stable from a press_valid until the next press_valid.
module keypad_event_fsm
  import keypad_pkg::*;
#(
  parameter int N  = 16,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_stb,
  input  logic [N-1:0]  deb,
  output logic [KW-1:0] key,
  output logic          press_valid,
  output logic          release_valid,
  output logic          key_down,
  output logic          multi
);

  state_t          state;
  state_t          state_n;
  logic [KW-1:0]   key_n;
  logic            press_n;
  logic            release_n;
  int unsigned     n_keys;
  logic [N-1:0]    held_mask;
  logic [KW-1:0]   single_idx;

  // Key count, mask of the currently held key and index of the lowest set bit
  always_comb begin
    n_keys     = popcount(64'(deb));
    held_mask  = N'(1) << key;
    single_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (deb[i]) single_idx = KW'(i);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      key           <= '0;
      press_valid   <= 1'b0;
      release_valid <= 1'b0;
    end else begin
      state         <= state_n;
      key           <= key_n;
      press_valid   <= press_n;
      release_valid <= release_n;
    end
  end

  // Next-state decision, once per frame
  always_comb begin
    state_n = state;
    if (frame_stb) begin
      case (state)
        IDLE: begin
          if (n_keys == 1)     state_n = HELD;
          else if (n_keys > 1) state_n = BLOCKED;
        end
        HELD: begin
          if (n_keys == 0)             state_n = IDLE;
          else if (deb != held_mask)   state_n = BLOCKED;
        end
        BLOCKED: begin
          if (n_keys == 0) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Event outputs; a held key leaving (alone or into a chord) emits its release
  always_comb begin
    press_n   = 1'b0;
    release_n = 1'b0;
    key_n     = key;
    if (frame_stb) begin
      if (state == IDLE && n_keys == 1) begin
        press_n = 1'b1;
        key_n   = single_idx;
      end else if (state == HELD && (n_keys == 0 || deb != held_mask)) begin
        release_n = 1'b1;
      end
    end
  end

  // Level outputs: key_down covers the release pulse cycle as well
  always_comb begin
    key_down = (state == HELD) || release_valid;
    multi    = (state == BLOCKED);
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: row synchroniser, column strobe generation,
// per-frame snapshot, whole-frame debounce and the event FSM.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_US        = 1000,
  parameter int SETTLE_CYCLES  = 100,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key,
  output logic            press_valid,
  output logic            release_valid,
  output logic            key_down,
  output logic            multi
);

  localparam int N     = ROWS * COLS;
  localparam int DWELL = CLK_HZ / 1_000_000 * SCAN_US;
  localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW    = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DW-1:0] SETTLE_AT  = DW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
  localparam logic [SW-1:0] STABLE_ACC = SW'(DEBOUNCE_SCANS - 1);

  // Parameter sanity at elaboration
  if (ROWS < 1 || ROWS > 8 || COLS < 1 || COLS > 8) begin : g_bad_size
    $error("keypad_scan_debounce: ROWS and COLS must be within 1..8");
  end
  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES >= DWELL) begin : g_bad_settle
    $error("keypad_scan_debounce: SETTLE_CYCLES must be >= 3 and < DWELL");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("keypad_scan_debounce: DEBOUNCE_SCANS must be >= 1");
  end

  logic [ROWS-1:0] row_s1;
  logic [ROWS-1:0] row_s2;
  logic [DW-1:0]   dwell_cnt;
  logic [CW-1:0]   col_idx;
  logic [N-1:0]    snap;
  logic [N-1:0]    prev;
  logic [N-1:0]    deb;
  logic [SW-1:0]   stable_cnt;
  logic [SW-1:0]   stable_n;
  logic            frame_end;
  logic            frame_stb;

  // Two-flop synchroniser; reset to "released" (rows idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // Dwell counter, column index and the active-low column strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
      col       <= '1;
    end else begin
      if (dwell_cnt == '0) col <= ~(COLS'(1) << col_idx);
      if (dwell_cnt == DWELL_LAST) begin
        dwell_cnt <= '0;
        col_idx   <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  // Capture the settled rows of the driven column into the frame snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
    end else if (dwell_cnt == SETTLE_AT) begin
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          if (col_idx == CW'(c)) snap[r * COLS + c] <= ~row_s2[r];
        end
      end
    end
  end

  // Frame boundary and the stable-count update it implies
  always_comb begin
    frame_end = (dwell_cnt == DWELL_LAST) && (col_idx == COL_LAST);
    if (snap == prev) stable_n = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 1'b1;
    else              stable_n = '0;
  end

  // Whole-frame debounce; deb follows a snapshot once it has repeated enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      deb        <= '0;
      stable_cnt <= '0;
      frame_stb  <= 1'b0;
    end else begin
      frame_stb <= frame_end;
      if (frame_end) begin
        prev       <= snap;
        stable_cnt <= stable_n;
        if (stable_n == STABLE_ACC) deb <= snap;
      end
    end
  end

  keypad_event_fsm #(
    .N  (N),
    .KW (KW)
  ) u_event_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_stb     (frame_stb),
    .deb           (deb),
    .key           (key),
    .press_valid   (press_valid),
    .release_valid (release_valid),
    .key_down      (key_down),
    .multi         (multi)
  );

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with an ideal 4x4 keypad model.
module tb_keypad_scan_debounce;
  import keypad_pkg::*;

  localparam int FRAME = 40;
  localparam int BOUND = 5 * FRAME + 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       press_valid;
  logic       release_valid;
  logic       key_down;
  logic       multi;
  logic [15:0] pressed;

  int checks;
  int errors;

  int         press_cnt;
  int         release_cnt;
  int         both_cnt;
  int         glitch_cnt;
  logic [3:0] last_press_key;
  logic [3:0] last_rel_key;
  logic       rel_key_down;
  logic [3:0] key_prev;

  keypad_scan_debounce #(
    .CLK_HZ         (1_000_000),
    .ROWS           (4),
    .COLS           (4),
    .SCAN_US        (10),
    .SETTLE_CYCLES  (3),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .row           (row),
    .col           (col),
    .key           (key),
    .press_valid   (press_valid),
    .release_valid (release_valid),
    .key_down      (key_down),
    .multi         (multi)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal keypad: a closed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r * 4 + c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Event monitor
  always @(negedge clk) begin
    if (press_valid) begin
      press_cnt      <= press_cnt + 1;
      last_press_key <= key;
    end
    if (release_valid) begin
      release_cnt  <= release_cnt + 1;
      last_rel_key <= key;
      rel_key_down <= key_down;
    end
    if (press_valid && release_valid) both_cnt <= both_cnt + 1;
    if (rst_n && key !== key_prev && !press_valid) glitch_cnt <= glitch_cnt + 1;
    key_prev <= key;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_press(output logic seen);
    int start;
    start = press_cnt;
    seen  = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk); #1;
      if (press_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(output logic seen);
    int start;
    start = release_cnt;
    seen  = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk); #1;
      if (release_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_multi(input logic level, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk); #1;
      if (multi === level) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  logic [3:0] col_exp [5];
  logic       seen;
  int         p_base;
  int         r_base;

  initial begin
    checks = 0; errors = 0;
    press_cnt = 0; release_cnt = 0; both_cnt = 0; glitch_cnt = 0;
    last_press_key = '0; last_rel_key = '0; rel_key_down = 1'b0; key_prev = '0;
    col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    pressed = '0;
    rst_n   = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_col", 32'(col), 32'hF);
    chk("rst_key", 32'(key), 0);
    chk("rst_press", 32'(press_valid), 0);
    chk("rst_release", 32'(release_valid), 0);
    chk("rst_key_down", 32'(key_down), 0);
    chk("rst_multi", 32'(multi), 0);

    // Column sequence after reset release, 10 cycles per column
    rst_n = 1'b1;
    @(negedge clk);
    chk("col_0", 32'(col), 32'(col_exp[0]));
    for (int k = 1; k < 5; k++) begin
      repeat (10) @(negedge clk);
      chk($sformatf("col_%0d", k), 32'(col), 32'(col_exp[k]));
    end
    repeat (3 * FRAME) @(negedge clk);
    #1;
    chk("idle_no_press", press_cnt, 0);
    chk("idle_no_release", release_cnt, 0);
    chk("idle_key_down", 32'(key_down), 0);
    chk("idle_multi", 32'(multi), 0);

    // Clean press / release of row 2 column 1 (key 9, legend 8)
    pressed[9] = 1'b1;
    wait_press(seen);
    chk("p9_seen", 32'(seen), 1);
    chk("p9_key", 32'(key), 9);
    chk("p9_legend", 32'(KEY_LEGEND[key]), 32'h8);
    chk("p9_key_down", 32'(key_down), 1);
    repeat (FRAME) @(negedge clk);
    #1;
    chk("p9_still_down", 32'(key_down), 1);
    pressed[9] = 1'b0;
    wait_release(seen);
    chk("r9_seen", 32'(seen), 1);
    chk("r9_key", 32'(key), 9);
    chk("r9_key_down_incl", 32'(key_down), 1);
    @(negedge clk); #1;
    chk("r9_key_down_low", 32'(key_down), 0);
    chk("r9_counts", press_cnt * 16 + release_cnt, 32'h11);

    // Bounce: toggle every 15 cycles for 200 cycles, then open
    p_base = press_cnt; r_base = release_cnt;
    for (int i = 0; i < 200; i++) begin
      if (i % 15 == 0) pressed[9] = ~pressed[9];
      @(negedge clk);
    end
    pressed[9] = 1'b0;
    repeat (6 * FRAME) @(negedge clk);
    #1;
    chk("bounce_no_press", press_cnt, p_base);
    chk("bounce_no_release", release_cnt, r_base);
    chk("bounce_key_down", 32'(key_down), 0);

    // Chord: key 0 held, then key 5 added
    pressed[0] = 1'b1;
    wait_press(seen);
    chk("c0_seen", 32'(seen), 1);
    chk("c0_key", 32'(key), 0);
    chk("c0_legend", 32'(KEY_LEGEND[key]), 32'h1);
    pressed[5] = 1'b1;
    wait_release(seen);
    chk("c0_rel_seen", 32'(seen), 1);
    chk("c0_rel_key", 32'(last_rel_key), 0);
    chk("c0_rel_multi", 32'(multi), 1);
    @(negedge clk); #1;
    chk("c0_blocked_down", 32'(key_down), 0);
    p_base = press_cnt; r_base = release_cnt;
    pressed[0] = 1'b0;
    repeat (6 * FRAME) @(negedge clk);
    #1;
    chk("c0_single_blocked", 32'(multi), 1);
    chk("c0_no_press", press_cnt, p_base);
    pressed[5] = 1'b0;
    wait_multi(1'b0, seen);
    chk("c0_multi_clear", 32'(seen), 1);
    chk("c0_end_press", press_cnt, p_base);
    chk("c0_end_release", release_cnt, r_base);
    chk("c0_key_kept", 32'(key), 0);

    // Simultaneous first press of keys 3 and 12
    p_base = press_cnt; r_base = release_cnt;
    pressed[3]  = 1'b1;
    pressed[12] = 1'b1;
    wait_multi(1'b1, seen);
    chk("s_multi", 32'(seen), 1);
    chk("s_no_press", press_cnt, p_base);
    chk("s_key_down", 32'(key_down), 0);
    pressed[3]  = 1'b0;
    pressed[12] = 1'b0;
    wait_multi(1'b0, seen);
    chk("s_idle", 32'(seen), 1);
    chk("s_no_release", release_cnt, r_base);

    // Reset while a key is held; a fresh press follows after reset
    pressed[9] = 1'b1;
    wait_press(seen);
    chk("h_seen", 32'(seen), 1);
    chk("h_key_down", 32'(key_down), 1);
    r_base = release_cnt;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("h_rst_col", 32'(col), 32'hF);
    chk("h_rst_key", 32'(key), 0);
    chk("h_rst_key_down", 32'(key_down), 0);
    chk("h_rst_multi", 32'(multi), 0);
    chk("h_rst_press", 32'(press_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_press(seen);
    chk("h_repress_seen", 32'(seen), 1);
    chk("h_repress_key", 32'(key), 9);
    chk("h_no_release", release_cnt, r_base);
    pressed[9] = 1'b0;
    wait_release(seen);
    chk("h_release_seen", 32'(seen), 1);
    chk("h_release_key", 32'(last_rel_key), 9);

    // Global properties
    chk("no_press_and_release", both_cnt, 0);
    chk("key_only_with_press", glitch_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Parametrised matrix-keypad scanner with row synchronisation, whole-frame debouncing and press/release event generation. Drives active-low column strobes, samples active-low rows, and reports a single debounced key as a one-clock press pulse and a one-clock release pulse. Multi-key chords are flagged and suppressed. It sits between the Pmod keypad pins and the lab's key-consuming logic, replacing the fixed 4×4, press-only scanner.

## Interface
- CLK_HZ, 100_000_000, clock frequency in Hz
- ROWS, 4, number of row inputs, range 1..8
- COLS, 4, number of column outputs, range 1..8
- SCAN_US, 1000, per-column dwell in µs
- SETTLE_CYCLES, 100, cycles from column change to row sample; must be at least 3 and less than DWELL (elaboration assertion)
- DEBOUNCE_SCANS, 4, identical consecutive frames required before accepting; must be at least 1
- KW, $clog2(ROWS*COLS), key index width (derived localparam)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row  in  ROWS  raw keypad rows; 0 means a key is closed on the driven column
- col  out  COLS  column strobes; exactly one bit 0 while scanning
- key  out  KW  index of the reported key, row*COLS+col
- press_valid  out  1  one-clock pulse; a new single key is accepted
- release_valid  out  1  one-clock pulse; the reported key was released; `key` still holds its index
- key_down  out  1  level; high from press_valid to release_valid inclusive
- multi  out  1  level; high while in BLOCKED

## Operation
- `row` passes through a 2-flop synchroniser before use.
- DWELL = CLK_HZ/1_000_000*SCAN_US cycles.
- The dwell counter runs 0..DWELL-1. The column index runs 0..COLS-1 and wraps.
- At dwell count 0, drive `col` low on the current column only.
- At dwell count SETTLE_CYCLES, capture the inverted synchronised rows into the frame snapshot bits for that column (1 = pressed).
- After the last column's dwell, the frame is complete. Compare the snapshot with the previous frame:
  - If equal, increment the stable count, saturating at DEBOUNCE_SCANS.
  - Otherwise clear the stable count to 0.
  - When the stable count reaches DEBOUNCE_SCANS-1 on an equal frame, copy the snapshot to `deb`.
- The event FSM is evaluated once per frame, in the cycle after `deb` updates. It uses n, the population count of `deb`:
  - IDLE: n==1 → press_valid, load `key`, go to HELD. n>1 → go to BLOCKED. n==0 → stay.
  - HELD: n==0 → release_valid, go to IDLE. `deb` not equal to the held key alone (a different key, or more than one key) → release_valid for the held key, go to BLOCKED.
  - BLOCKED: n==0 → go to IDLE. Otherwise stay; no events.
- Press and release pulses never assert in the same cycle.
- Reset values:
  - col all ones
  - key 0, press_valid 0, release_valid 0, key_down 0, multi 0
  - snapshots and `deb` all 0
  - stable count 0, state IDLE, dwell counter 0, column index 0
- Reset mid-frame discards the partial frame and any pending event. No release is emitted for a key held across reset.

## Timing
- Frame length is COLS*DWELL cycles. All events align to frame boundaries, 1 cycle after the `deb` update.
- Latency from a clean press (stable before a frame start) to press_valid is at most (DEBOUNCE_SCANS+1) frames + 3 cycles. Release latency is the same bound.
- A bounce shorter than one frame never produces an event once DEBOUNCE_SCANS ≥ 2.
- `key` changes only together with press_valid.
- The first column strobe asserts on the first clk edge after rst_n deasserts.

## Structure
- Package `keypad_pkg` holds:
  - the state enum {IDLE, HELD, BLOCKED}
  - the 16-entry 4×4 hex legend constant, indexed by key index. Column 0 rows 0..3 = 1,4,7,0; column 1 = 2,5,8,F; column 2 = 3,6,9,E; column 3 = A,B,C,D
  - a popcount function
- Sub-module `keypad_event_fsm` takes `deb` and a frame strobe and produces key, press_valid, release_valid, key_down and multi. The top level contains the synchroniser, scan counters and debounce.

## Test plan
Bench parameters: CLK_HZ=1_000_000, SCAN_US=10, ROWS=COLS=4, SETTLE_CYCLES=3, DEBOUNCE_SCANS=3. This gives DWELL=10 and a 40-cycle frame.

- Reset, no keys:
  - stimulus: release rst_n with all rows high
  - response: col cycles 1110, 1101, 1011, 0111 every 10 cycles; no events; all outputs at reset values
- Clean press and release of row 2, column 1 (key 9, hex 8):
  - stimulus: hold row 2 low while col[1]=0, then release
  - response: press_valid with key=9 within 4 frames + 3 cycles; key_down high; release_valid with key=9 after release
- Bounce:
  - stimulus: toggle the row 2 / column 1 closure every 15 cycles for 200 cycles, then open
  - response: no press_valid, no release_valid
- Chord:
  - stimulus: press key 0, wait for press_valid, then also press key 5
  - response: release_valid with key=0; multi=1; further presses give no events until all keys are released; then multi=0
- Simultaneous first press:
  - stimulus: keys 3 and 12 close in the same frame
  - response: multi=1, no press_valid; releasing both returns to IDLE
- Reset mid-hold:
  - stimulus: assert rst_n low while key_down=1
  - response: outputs return to reset values immediately; after reset with the key still held, a fresh press_valid follows within the latency bound
